// File: rtl/monitor_bus_pkg.sv
// Shared definitions for the monitor card bus master:
// FSM state encoding, bus idle levels and the phase-advance helper.
package monitor_bus_pkg;

    typedef logic [2:0] state_t;

    // Consecutive encoding lets the phase states advance by increment.
    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_A_SETUP  = 3'd1;
    localparam state_t ST_A_STROBE = 3'd2;
    localparam state_t ST_A_HOLD   = 3'd3;
    localparam state_t ST_D_SETUP  = 3'd4;
    localparam state_t ST_D_STROBE = 3'd5;
    localparam state_t ST_D_HOLD   = 3'd6;
    localparam state_t ST_DONE     = 3'd7;

    // Bus levels whenever no transaction owns the card bus.
    localparam logic       SLOT_IDLE   = 1'b1;
    localparam logic       CLK_RW_IDLE = 1'b1;
    localparam logic       AX_D_IDLE   = 1'b1;
    localparam logic       R_WX_IDLE   = 1'b1;
    localparam logic       AD_OE_IDLE  = 1'b0;
    localparam logic [7:0] AD_IDLE     = 8'h00;

    function automatic state_t next_phase(state_t s);
        return s + 3'd1;
    endfunction

endpackage

// File: rtl/monitor_bus_irq_sync.sv
// Card interrupt synchroniser and falling-edge latch.
// Ports: clk_i, rst_ni (async low), irq_ni (async, active-low), ack_i, pending_o.
module monitor_bus_irq_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic irq_ni,
    input  logic ack_i,
    output logic pending_o
);

    logic sync1_q, sync2_q, prev_q;
    logic pending_q, pending_d;
    logic fall;

    // prev_q holds the previous synchronised level for edge detection.
    assign fall = prev_q & ~sync2_q;

    // A fresh edge wins over a simultaneous acknowledge.
    always_comb begin
        pending_d = pending_q;
        if (fall) begin
            pending_d = 1'b1;
        end else if (ack_i) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            prev_q    <= 1'b1;
            pending_q <= 1'b0;
        end else begin
            sync1_q   <= irq_ni;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/monitor_bus_master.sv
// Monitor card bus master: one command -> address phase + data phase
// (setup/strobe/hold each PHASE_CYCLES clocks) on a multiplexed 8-bit bus.
// Ports: clk_50mhz_in, reset_x (async low); cmd_valid/cmd_ready, cmd_addr,
// cmd_wdata, cmd_rnw; rsp_valid, rsp_rdata; slot_x_int_x, clk_rw, ax_d, r_wx;
// ad_out, ad_oe, ad_in; irq_x, irq_ack, irq_pending.
// Define MONITOR_BUS_IRQ_EN to build the interrupt synchroniser/latch.
module monitor_bus_master
    import monitor_bus_pkg::*;
#(
    parameter int PHASE_CYCLES = 8
) (
    input  logic       clk_50mhz_in,
    input  logic       reset_x,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    input  logic       cmd_rnw,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       slot_x_int_x,
    output logic       clk_rw,
    output logic       ax_d,
    output logic       r_wx,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    input  logic [7:0] ad_in,
    input  logic       irq_x,
    input  logic       irq_ack,
    output logic       irq_pending
);

    localparam logic [7:0] LAST_CNT = 8'(PHASE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] rdata_q, rdata_d;
    logic [7:0] addr_q, wdata_q;
    logic       rnw_q;
    logic       ready_en_q;

    logic accept;
    logic phase_last;
    logic in_addr, in_data, in_bus;
    logic strobe;
    logic wr_data;

    // Held low through reset and its first clock afterwards.
    assign cmd_ready  = ready_en_q && (state_q == ST_IDLE);
    assign accept     = cmd_valid && cmd_ready;
    assign phase_last = (cnt_q == LAST_CNT);

    assign in_addr = (state_q == ST_A_SETUP) || (state_q == ST_A_STROBE) ||
                     (state_q == ST_A_HOLD);
    assign in_data = (state_q == ST_D_SETUP) || (state_q == ST_D_STROBE) ||
                     (state_q == ST_D_HOLD);
    assign in_bus  = in_addr || in_data;
    assign strobe  = (state_q == ST_A_STROBE) || (state_q == ST_D_STROBE);
    assign wr_data = in_data && !rnw_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_A_SETUP;
                    cnt_d   = 8'd0;
                    if (!cmd_rnw) begin
                        rdata_d = 8'h00;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                if (phase_last) begin
                    cnt_d   = 8'd0;
                    state_d = next_phase(state_q);
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
                // Card data is valid by the end of the data strobe.
                if ((state_q == ST_D_STROBE) && phase_last && rnw_q) begin
                    rdata_d = ad_in;
                end
            end
        endcase
    end

    always_ff @(posedge clk_50mhz_in or negedge reset_x) begin
        if (!reset_x) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 8'd0;
            rdata_q    <= 8'h00;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            ready_en_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_50mhz_in or negedge reset_x) begin
        if (!reset_x) begin
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            rnw_q   <= 1'b1;
        end else if (accept) begin
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            rnw_q   <= cmd_rnw;
        end
    end

    // Bus pins decode straight from the state so reset idles them at once.
    assign slot_x_int_x = in_bus ? 1'b0 : SLOT_IDLE;
    assign ax_d         = in_addr ? 1'b0 : AX_D_IDLE;
    assign clk_rw       = strobe ? 1'b0 : CLK_RW_IDLE;
    assign r_wx         = (in_bus && !rnw_q) ? 1'b0 : R_WX_IDLE;
    assign ad_oe        = (in_addr || wr_data) ? 1'b1 : AD_OE_IDLE;
    assign ad_out       = in_addr ? addr_q :
                          wr_data ? wdata_q : AD_IDLE;

    assign rsp_valid = (state_q == ST_DONE);
    assign rsp_rdata = rdata_q;

`ifdef MONITOR_BUS_IRQ_EN
    monitor_bus_irq_sync u_irq (
        .clk_i     (clk_50mhz_in),
        .rst_ni    (reset_x),
        .irq_ni    (irq_x),
        .ack_i     (irq_ack),
        .pending_o (irq_pending)
    );
`else
    logic unused_irq;
    assign unused_irq  = irq_x ^ irq_ack;
    assign irq_pending = 1'b0;
`endif

endmodule

// File: tb/tb_monitor_bus_master.sv
// Bench for monitor_bus_master: timeline model for PHASE_CYCLES=8,
// directed literal checks, and a PHASE_CYCLES=1 instance.
module tb_monitor_bus_master;

    localparam int P = 8;

    logic clk = 1'b0;
    logic reset_x = 1'b1;
    always #10 clk = ~clk;

    logic       cmd_valid = 1'b0, cmd_rnw = 1'b0;
    logic [7:0] cmd_addr = 8'h00, cmd_wdata = 8'h00;
    logic       cmd_ready, rsp_valid;
    logic [7:0] rsp_rdata, ad_out, ad_in;
    logic       slot_x_int_x, clk_rw, ax_d, r_wx, ad_oe;
    logic       irq_x = 1'b1, irq_ack = 1'b0, irq_pending;
    logic [7:0] card_val = 8'h00;

    logic       cmd_valid1 = 1'b0;
    logic [7:0] cmd_addr1 = 8'h00, cmd_wdata1 = 8'h00;
    logic       cmd_ready1, rsp_valid1;
    logic [7:0] rsp_rdata1, ad_out1;
    logic       slot1, clk_rw1, ax_d1, r_wx1, ad_oe1, irq_pending1;

    // Card drives the bus only in the data phase of a read.
    assign ad_in = (!slot_x_int_x && ax_d && !ad_oe) ? card_val : 8'hFF;

    monitor_bus_master #(.PHASE_CYCLES(P)) u8 (
        .clk_50mhz_in(clk), .reset_x(reset_x),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_rnw(cmd_rnw),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .slot_x_int_x(slot_x_int_x), .clk_rw(clk_rw), .ax_d(ax_d),
        .r_wx(r_wx), .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in),
        .irq_x(irq_x), .irq_ack(irq_ack), .irq_pending(irq_pending)
    );

    monitor_bus_master #(.PHASE_CYCLES(1)) u1 (
        .clk_50mhz_in(clk), .reset_x(reset_x),
        .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
        .cmd_addr(cmd_addr1), .cmd_wdata(cmd_wdata1), .cmd_rnw(1'b0),
        .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1),
        .slot_x_int_x(slot1), .clk_rw(clk_rw1), .ax_d(ax_d1),
        .r_wx(r_wx1), .ad_out(ad_out1), .ad_oe(ad_oe1), .ad_in(8'h00),
        .irq_x(1'b1), .irq_ack(1'b0), .irq_pending(irq_pending1)
    );

    int errs = 0;
    int checks = 0;
    int cyc = 0;
    int n_rsp = 0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t",
                     nm, got, want, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (rsp_valid) n_rsp++;

    // Model: a transaction is a timeline t=1..6P on the bus, DONE at 6P+1.
    bit         m_busy = 0, m_en = 0, m_rnw = 0;
    int         m_t = 0;
    logic [7:0] m_addr = 0, m_wdata = 0, m_rdata = 0;
    bit         m_pend = 0, h1 = 1, h2 = 1, h3 = 1;

    always @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            m_busy = 0; m_en = 0; m_t = 0; m_rdata = 0;
            m_pend = 0; h1 = 1; h2 = 1; h3 = 1;
        end else begin
            if (m_busy) begin
                if (m_t == 5 * P && m_rnw) m_rdata = ad_in;
                if (m_t == 6 * P + 1) m_busy = 0;
                else m_t++;
            end else if (m_en && cmd_valid) begin
                m_busy = 1; m_t = 1;
                m_addr = cmd_addr; m_wdata = cmd_wdata; m_rnw = cmd_rnw;
                if (!cmd_rnw) m_rdata = 8'h00;
            end
            m_en = 1;
`ifdef MONITOR_BUS_IRQ_EN
            // Synchronised level lags irq_x by two clocks.
            if (h3 && !h2) m_pend = 1;
            else if (irq_ack) m_pend = 0;
`endif
            h3 = h2; h2 = h1; h1 = irq_x;
        end
    end

    always @(negedge clk) begin
        bit m_act, e_oe;
        int p;
        m_act = m_busy && (m_t <= 6 * P);
        p = m_act ? (m_t - 1) / P : 0;
        e_oe = m_act && (p < 3 || !m_rnw);
        chk("cmd_ready", cmd_ready, m_en && !m_busy);
        chk("slot", slot_x_int_x, !m_act);
        chk("ax_d", ax_d, !(m_act && p < 3));
        chk("clk_rw", clk_rw, !(m_act && (p == 1 || p == 4)));
        chk("r_wx", r_wx, !(m_act && !m_rnw));
        chk("ad_oe", ad_oe, e_oe);
        if (e_oe) chk("ad_out", ad_out, (p < 3) ? m_addr : m_wdata);
        else if (!reset_x) chk("ad_out_rst", ad_out, 8'h00);
        chk("rsp_valid", rsp_valid, m_busy && m_t == 6 * P + 1);
        chk("rsp_rdata", rsp_rdata, m_rdata);
        chk("irq_pending", irq_pending, m_pend);
    end

    task automatic start_cmd(input logic [7:0] a, input logic [7:0] d,
                             input logic r);
        @(negedge clk);
        cmd_addr = a; cmd_wdata = d; cmd_rnw = r; cmd_valid = 1'b1;
    endtask

    // Returns the cycle count right after the accepting edge.
    task automatic wait_accept(output int acc);
        int n = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            checks++; errs++;
            $display("FAIL accept_timeout actual=0 required=1");
        end
        @(posedge clk);
        #1 acc = cyc;
    endtask

    task automatic wait_rsp(output int at);
        int n = 0;
        while (!rsp_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) begin
            checks++; errs++;
            $display("FAIL rsp_timeout actual=0 required=1");
        end
        at = cyc;
    endtask

`ifdef MONITOR_BUS_IRQ_EN
    localparam logic IRQ_EXP = 1'b1;
`else
    localparam logic IRQ_EXP = 1'b0;
`endif

    initial begin
        int a, a2, r, ns, nc, rv_t, base;
        logic [7:0] ad1, ad2;
        logic [8:1] s_h, c_h, x_h, v_h;
        logic [7:0] o1, o4, rd7;

        #1 reset_x = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_slot", slot_x_int_x, 1'b1);
        chk("rst_clk_rw", clk_rw, 1'b1);
        chk("rst_ax_d", ax_d, 1'b1);
        chk("rst_r_wx", r_wx, 1'b1);
        chk("rst_ad_oe", ad_oe, 1'b0);
        chk("rst_ad_out", ad_out, 8'h00);
        chk("rst_rdata", rsp_rdata, 8'h00);
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        chk("rst_irq", irq_pending, 1'b0);
        @(negedge clk) #2 reset_x = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", cmd_ready, 1'b1);

        // Write 0x05 / 0xA3.
        start_cmd(8'h05, 8'hA3, 1'b0);
        wait_accept(a);
        @(negedge clk) cmd_valid = 1'b0;
        ns = 0; nc = 0; rv_t = 0; ad1 = 0; ad2 = 0;
        for (int k = 0; k < 55; k++) begin
            if (!slot_x_int_x) ns++;
            if (!clk_rw) nc++;
            if (rsp_valid) rv_t = cyc - a + 1;
            if (cyc - a + 1 == 1) ad1 = ad_out;
            if (cyc - a + 1 == 25) ad2 = ad_out;
            if (rsp_valid) chk("wr_rdata", rsp_rdata, 8'h00);
            @(negedge clk);
        end
        chk("wr_slot_low", ns, 48);
        chk("wr_strobe_low", nc, 16);
        chk("wr_rsp_clock", rv_t, 49);
        chk("wr_addr_out", ad1, 8'h05);
        chk("wr_data_out", ad2, 8'hA3);

        // Read 0x10, card returns 0x5C.
        card_val = 8'h5C;
        start_cmd(8'h10, 8'h00, 1'b1);
        wait_accept(a);
        @(negedge clk) cmd_valid = 1'b0;
        while (cyc - a + 1 < 30) @(negedge clk);
        chk("rd_oe_data", ad_oe, 1'b0);
        chk("rd_ax_d", ax_d, 1'b1);
        wait_rsp(r);
        chk("rd_rsp_clock", r - a + 1, 49);
        chk("rd_rdata", rsp_rdata, 8'h5C);

        // Back-to-back write then read with cmd_valid held.
        card_val = 8'hC7;
        start_cmd(8'h22, 8'h7E, 1'b0);
        wait_accept(a);
        @(negedge clk);
        cmd_addr = 8'h33; cmd_wdata = 8'h00; cmd_rnw = 1'b1;
        wait_accept(a2);
        @(negedge clk) cmd_valid = 1'b0;
        chk("b2b_gap", a2 - a, 6 * P + 2);
        wait_rsp(r);
        chk("b2b_rdata", rsp_rdata, 8'hC7);

        // Reset in the middle of the data strobe.
        start_cmd(8'h44, 8'h99, 1'b0);
        wait_accept(a);
        @(negedge clk) cmd_valid = 1'b0;
        while (cyc - a + 1 < 4 * P + 4) @(negedge clk);
        chk("pre_rst_strobe", clk_rw, 1'b0);
        base = n_rsp;
        #2 reset_x = 1'b0;
        #1;
        chk("mid_rst_slot", slot_x_int_x, 1'b1);
        chk("mid_rst_clk_rw", clk_rw, 1'b1);
        chk("mid_rst_ax_d", ax_d, 1'b1);
        chk("mid_rst_r_wx", r_wx, 1'b1);
        chk("mid_rst_ad_oe", ad_oe, 1'b0);
        chk("mid_rst_ready", cmd_ready, 1'b0);
        @(negedge clk);
        @(negedge clk) #2 reset_x = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", cmd_ready, 1'b1);
        repeat (60) @(negedge clk);
        chk("dropped_no_rsp", n_rsp, base);

        // Interrupt: ack lands on the synchronised edge.
        @(negedge clk) irq_x = 1'b0;
        @(negedge clk);
        @(negedge clk) irq_ack = 1'b1;
        @(negedge clk) irq_ack = 1'b0;
        chk("irq_edge_vs_ack", irq_pending, IRQ_EXP);
        repeat (2) @(negedge clk);
        chk("irq_held", irq_pending, IRQ_EXP);
        irq_ack = 1'b1;
        @(negedge clk) irq_ack = 1'b0;
        chk("irq_acked", irq_pending, 1'b0);
        irq_x = 1'b1;
        repeat (4) @(negedge clk);
        chk("irq_rise_ignored", irq_pending, 1'b0);
        irq_x = 1'b0;
        repeat (4) @(negedge clk);
        chk("irq_plain_edge", irq_pending, IRQ_EXP);
        irq_ack = 1'b1;
        @(negedge clk) irq_ack = 1'b0;
        irq_x = 1'b1;

        // PHASE_CYCLES=1 write 0x5A / 0x3C.
        @(negedge clk);
        cmd_addr1 = 8'h5A; cmd_wdata1 = 8'h3C; cmd_valid1 = 1'b1;
        begin
            int n = 0;
            while (!cmd_ready1 && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("p1_ready", cmd_ready1, 1'b1);
        end
        @(posedge clk);
        #1 a = cyc;
        @(negedge clk) cmd_valid1 = 1'b0;
        s_h = 0; c_h = 0; x_h = 0; v_h = 0; o1 = 0; o4 = 0; rd7 = 8'hFF;
        for (int t = 1; t <= 8; t++) begin
            s_h[t] = slot1; c_h[t] = clk_rw1; x_h[t] = ax_d1;
            v_h[t] = rsp_valid1;
            if (t == 1) o1 = ad_out1;
            if (t == 4) o4 = ad_out1;
            if (t == 7) rd7 = rsp_rdata1;
            @(negedge clk);
        end
        chk("p1_slot", s_h, 8'b1100_0000);
        chk("p1_clk_rw", c_h, 8'b1110_1101);
        chk("p1_ax_d", x_h, 8'b1111_1000);
        chk("p1_rsp_valid", v_h, 8'b0100_0000);
        chk("p1_addr", o1, 8'h5A);
        chk("p1_wdata", o4, 8'h3C);
        chk("p1_rdata", rd7, 8'h00);
        chk("p1_ready_again", cmd_ready1, 1'b1);
        chk("p1_irq", irq_pending1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/monitor_bus_master.md
MONITOR_BUS_MASTER -- requirements
Module: monitor_bus_master

Interface
REQ-001 SHALL have parameter PHASE_CYCLES, default 8, clocks per bus sub-phase (setup/strobe/hold); legal range 1..255.
REQ-002 SHALL have clk_50mhz_in  input  1  system clock, 50 MHz; all logic on its rising edge.
REQ-003 SHALL have reset_x  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have cmd_valid/cmd_ready  input/output  1/1  command handshake.
REQ-005 SHALL have cmd_addr, cmd_wdata, cmd_rnw  input  8,8,1  register address, write data, 1=read.
REQ-006 SHALL have rsp_valid, rsp_rdata  output  1,8  completion pulse and read data.
REQ-007 SHALL have slot_x_int_x, clk_rw, ax_d, r_wx  output  1 each  card bus controls: slot select (active-low), strobe (active-low), 0=address/1=data, 1=read/0=write.
REQ-008 SHALL have ad_out, ad_oe, ad_in  output/output/input  8,1,8  multiplexed bus drive, drive enable, sampled bus.
REQ-009 SHALL have irq_x, irq_ack, irq_pending  input/input/output  1 each  card interrupt (active-low, async), acknowledge, latched interrupt.

Function
REQ-010 SHALL assert cmd_ready only in IDLE; command accepted on a cycle with cmd_valid=1 and cmd_ready=1, fields latched that cycle.
REQ-011 SHALL sequence IDLE -> A_SETUP -> A_STROBE -> A_HOLD -> D_SETUP -> D_STROBE -> D_HOLD -> DONE -> IDLE, each non-IDLE/DONE state lasting exactly PHASE_CYCLES clocks, DONE one clock.
REQ-012 SHALL hold slot_x_int_x=0 from A_SETUP through D_HOLD, 1 otherwise.
REQ-013 SHALL drive ax_d=0 in A_*, ax_d=1 in D_*, ax_d=1 in IDLE/DONE.
REQ-014 SHALL drive clk_rw=0 only in A_STROBE and D_STROBE, 1 otherwise.
REQ-015 SHALL drive r_wx=0 in A_* and D_* states of writes; r_wx=1 in all other cases.
REQ-016 SHALL drive ad_out=cmd_addr with ad_oe=1 in A_*; ad_out=cmd_wdata with ad_oe=1 in D_* of writes; ad_oe=0 in D_* of reads, IDLE, DONE.
REQ-017 SHALL capture ad_in into rsp_rdata on the last clock of D_STROBE for reads; rsp_rdata SHALL be 0x00 after writes.
REQ-018 SHALL pulse rsp_valid=1 for exactly the DONE clock; total latency accept-to-rsp_valid = 6*PHASE_CYCLES+1 clocks.
REQ-019 SHALL accept a new command the cycle after DONE (back-to-back supported, no gap beyond IDLE cycle).
REQ-020 SHALL synchronise irq_x with a two-flop synchroniser and set irq_pending on a synchronised 1->0 edge.
REQ-021 SHALL clear irq_pending on irq_ack=1; simultaneous new edge and irq_ack SHALL leave irq_pending=1.
REQ-022 SHALL use a phase counter of 8 bits; PHASE_CYCLES=1 SHALL yield single-clock phases without wrap error.

Reset
REQ-023 SHALL on reset_x=0, immediately and asynchronously: state IDLE, slot_x_int_x=1, clk_rw=1, ax_d=1, r_wx=1, ad_oe=0, ad_out=0x00, rsp_valid=0, rsp_rdata=0x00, irq_pending=0, cmd_ready=0, synchroniser flops=1.
REQ-024 SHALL assert cmd_ready=1 on the first clock after reset_x deasserts; a transaction interrupted by reset SHALL be dropped with no rsp_valid.

Configuration
REQ-025 SHALL compile interrupt logic (REQ-020/021) only when MONITOR_BUS_IRQ_EN is defined; without it irq_pending SHALL be constant 0 and irq_x/irq_ack ignored.

Structure
REQ-026 SHALL place the state enumeration and bus idle-level constants in shared package monitor_bus_pkg.
REQ-027 SHALL implement the irq synchroniser/edge latch as sub-module monitor_bus_irq_sync.

Verification
REQ-028 Write addr=0x05 data=0xA3, PHASE_CYCLES=8 -> slot low 48 clocks, two clk_rw low pulses of 8 clocks, ad_out 0x05 then 0xA3, rsp_valid at clock 49.
REQ-029 Read addr=0x10, card model drives ad_in=0x5C in data phase -> ad_oe=0 in D_*, rsp_rdata=0x5C with rsp_valid.
REQ-030 Back-to-back write then read with cmd_valid held -> second accept exactly one clock after first DONE.
REQ-031 reset_x pulsed low mid D_STROBE -> all bus outputs idle same cycle, no rsp_valid, cmd_ready=1 after release.
REQ-032 irq_x falls, irq_ack asserted on same cycle as synchronised edge -> irq_pending=1; later irq_ack alone -> 0; without MONITOR_BUS_IRQ_EN stays 0.
REQ-033 PHASE_CYCLES=1 write -> transaction completes, rsp_valid 7 clocks after accept.
